sobel_frame_emitter: RTL and testbench

//  Transmit-side framer for the edge-detect stream. Rebuilds the framed byte protocol that the

---
 rtl/sobel_frame_emitter.sv | 138 +++++++++++++
 tb/tb_sobel_frame_emitter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_emitter.sv
// Re-frames a bare pixel stream as width, height, pixels on a byte-wide valid/ready TX port.
// Pixels are buffered in a small FIFO; upstream cannot stall, so refused pixels raise a sticky overflow.
module sobel_frame_emitter #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk_a,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] cfg_width,
    input  logic [DATA_BITS-1:0] cfg_height,
    input  logic [DATA_BITS-1:0] pix_in,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    output logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = 16;

    typedef enum logic [2:0] {S_IDLE, S_HDR_W, S_HDR_H, S_PIXELS, S_DONE} state_t;
    state_t state, state_nx;

    logic [DATA_BITS-1:0] width_q, height_q;
    logic [CW-1:0]        total_q, in_cnt, out_cnt;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 fifo_full, fifo_empty, push, pop, tx_hs;
    logic                 tx_valid_nx;
    logic [DATA_BITS-1:0] tx_data_nx, fifo_head;

    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign fifo_head  = mem[rd_ptr];
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign tx_hs      = tx_valid && tx_ready;
    assign pix_ready  = busy && (state != S_DONE) && !fifo_full && (in_cnt < total_q);
    assign push       = pix_valid && pix_ready;

    // The TX register is reloaded whenever it is empty or being drained, so a
    // pixel can follow a handshake back-to-back.
    always_comb begin
        state_nx    = state;
        pop         = 1'b0;
        tx_valid_nx = tx_valid;
        tx_data_nx  = tx_data;
        case (state)
            S_IDLE: if (start) state_nx = S_HDR_W;
            S_HDR_W: begin
                if (!tx_valid) begin
                    tx_valid_nx = 1'b1;
                    tx_data_nx  = width_q;
                end else if (tx_ready) begin
                    state_nx    = S_HDR_H;
                    tx_valid_nx = 1'b1;
                    tx_data_nx  = height_q;
                end
            end
            S_HDR_H: begin
                if (tx_hs) begin
                    if (total_q == '0) begin
                        state_nx    = S_DONE;
                        tx_valid_nx = 1'b0;
                    end else begin
                        state_nx    = S_PIXELS;
                        pop         = !fifo_empty;
                        tx_valid_nx = !fifo_empty;
                        if (!fifo_empty) tx_data_nx = fifo_head;
                    end
                end
            end
            S_PIXELS: begin
                if (!tx_valid || tx_ready) begin
                    if (tx_hs && out_cnt == total_q - CW'(1)) begin
                        state_nx    = S_DONE;
                        tx_valid_nx = 1'b0;
                    end else begin
                        pop         = !fifo_empty;
                        tx_valid_nx = !fifo_empty;
                        if (!fifo_empty) tx_data_nx = fifo_head;
                    end
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_a) begin
        if (rst) begin
            state    <= S_IDLE;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            width_q  <= '0;
            height_q <= '0;
            total_q  <= '0;
            in_cnt   <= '0;
            out_cnt  <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_nx;
            tx_valid <= tx_valid_nx;
            tx_data  <= tx_data_nx;
            if (state == S_IDLE && start) begin
                width_q  <= cfg_width;
                height_q <= cfg_height;
                total_q  <= CW'(cfg_width) * CW'(cfg_height);
                in_cnt   <= '0;
                out_cnt  <= '0;
                overflow <= 1'b0;
            end else begin
                if (push) in_cnt <= in_cnt + CW'(1);
                if (state == S_PIXELS && tx_hs) out_cnt <= out_cnt + CW'(1);
                if (busy && pix_valid && !pix_ready) overflow <= 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_a) begin
        if (push) mem[wr_ptr] <= pix_in;
    end
endmodule

// File: tb/tb_sobel_frame_emitter.sv
// Directed bench: a frame-level scoreboard checks every cycle, plus literal byte sequences per scenario.
module tb_sobel_frame_emitter;
    typedef logic [7:0] bq_t[$];

    logic       clk_a = 1'b0;
    logic       rst, start, pix_valid, tx_ready;
    logic [7:0] cfg_width, cfg_height, pix_in;
    logic       pix_ready, tx_valid, busy, done, overflow;
    logic [7:0] tx_data;

    sobel_frame_emitter #(.DATA_BITS(8), .FIFO_DEPTH(4)) dut (
        .clk_a(clk_a), .rst(rst), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk_a = ~clk_a;

    int   n_tests = 0, n_fail = 0;
    // frame-level model state
    bq_t  exp_q, txlog;
    int   m_total, m_acc, m_sent, n_done;
    bit   m_busy, m_done, m_ovf, p_hold, chk_en;
    logic [7:0] p_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    task automatic chk_log(input string nm, input bq_t want);
        chk({nm, "_len"}, txlog.size(), want.size());
        for (int i = 0; i < want.size() && i < txlog.size(); i++)
            chk(nm, {24'h0, txlog[i]}, {24'h0, want[i]});
    endtask

    // Sampled at the falling edge: the values here are what the next rising edge commits.
    task automatic model_step();
        bit nd;
        if (chk_en) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("overflow", overflow, m_ovf);
            if (!m_busy || m_acc >= m_total) chk("pix_ready_low", pix_ready, 0);
            if (!m_busy || m_done) chk("tx_valid_low", tx_valid, 0);
            if (p_hold) begin
                chk("tx_hold_valid", tx_valid, 1);
                chk("tx_hold_data", tx_data, p_data);
            end
            if (done === 1'b1) n_done++;
        end
        if (rst) begin
            exp_q.delete();
            m_busy = 0; m_done = 0; m_ovf = 0; p_hold = 0;
            m_total = 0; m_acc = 0; m_sent = 0;
            return;
        end
        nd = 0;
        if (m_done) begin
            if (pix_valid) m_ovf = 1;
            m_busy = 0;
        end else if (m_busy) begin
            if (tx_valid && tx_ready) begin
                txlog.push_back(tx_data);
                if (exp_q.size() == 0) chk("tx_unexpected_byte", tx_data, 32'hFFFF_FFFF);
                else chk("tx_byte", tx_data, exp_q.pop_front());
                m_sent++;
                if (m_sent == m_total + 2) nd = 1;
            end
            if (pix_valid && !pix_ready) m_ovf = 1;
            if (pix_valid && pix_ready) begin
                exp_q.push_back(pix_in);
                m_acc++;
            end
        end else if (start) begin
            m_busy = 1; m_ovf = 0;
            m_total = cfg_width * cfg_height;
            m_acc = 0; m_sent = 0;
            exp_q.delete();
            exp_q.push_back(cfg_width);
            exp_q.push_back(cfg_height);
        end
        m_done = nd;
        p_hold = tx_valid && !tx_ready;
        p_data = tx_data;
    endtask

    task automatic tick();
        @(negedge clk_a);
        model_step();
        @(posedge clk_a);
        #1;
    endtask

    task automatic do_start(input logic [7:0] w, input logic [7:0] h);
        start = 1'b1; cfg_width = w; cfg_height = h;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int maxc);
        int c;
        c = 0;
        while (busy !== 1'b0 && c < maxc) begin
            tick();
            c++;
        end
        chk({nm, "_idle_in_time"}, (c < maxc), 1);
        chk({nm, "_all_bytes_sent"}, exp_q.size(), 0);
    endtask

    task automatic new_case();
        txlog.delete();
        n_done = 0;
    endtask

    initial begin
        bq_t want;
        int  idx;
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; tx_ready = 1'b0;
        cfg_width = '0; cfg_height = '0; pix_in = '0;
        chk_en = 0;
        tick(); tick();
        rst = 1'b0;
        chk_en = 1;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);

        // 3x2 frame, streaming pixels, TX always ready
        new_case(); tx_ready = 1'b1;
        do_start(8'd3, 8'd2);
        for (int i = 0; i < 6; i++) begin
            pix_valid = 1'b1; pix_in = 8'(8'h10 + i);
            tick();
        end
        pix_valid = 1'b0;
        wait_idle("t1", 40);
        want = '{8'h03, 8'h02, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        chk_log("t1_bytes", want);
        chk("t1_done_pulses", n_done, 1);
        chk("t1_overflow", overflow, 0);

        // same frame with a stuttering transmitter
        new_case(); idx = 0;
        do_start(8'd3, 8'd2);
        for (int c = 0; c < 300 && (idx < 6 || busy); c++) begin
            tx_ready  = 1'($urandom_range(0, 1));
            pix_valid = (idx < 6) && pix_ready;
            pix_in    = 8'(8'h10 + idx);
            tick();
            if (pix_valid) idx++;
        end
        pix_valid = 1'b0; tx_ready = 1'b1;
        wait_idle("t2", 20);
        chk_log("t2_bytes", want);
        chk("t2_done_pulses", n_done, 1);

        // empty frame: headers only; a stray pixel is refused and flagged
        new_case();
        do_start(8'd0, 8'd5);
        pix_valid = 1'b1; pix_in = 8'h99;
        tick();
        pix_valid = 1'b0;
        wait_idle("t4", 20);
        want = '{8'h00, 8'h05};
        chk_log("t4_bytes", want);
        chk("t4_done_pulses", n_done, 1);
        chk("t4_overflow", overflow, 1);

        // second start mid-frame is ignored; the accepted start clears overflow
        new_case();
        do_start(8'd2, 8'd2);
        chk("t6_overflow_cleared", overflow, 0);
        for (int i = 0; i < 4; i++) begin
            pix_valid = 1'b1; pix_in = 8'(8'h30 + i);
            start = (i == 1); cfg_width = 8'd9; cfg_height = 8'd9;
            tick();
        end
        pix_valid = 1'b0; start = 1'b0;
        wait_idle("t6", 40);
        want = '{8'h02, 8'h02, 8'h30, 8'h31, 8'h32, 8'h33};
        chk_log("t6_bytes", want);
        chk("t6_done_pulses", n_done, 1);

        // stalled TX: FIFO fills at 4, the rest are dropped
        new_case(); tx_ready = 1'b0;
        do_start(8'd8, 8'd1);
        for (int i = 0; i < 8; i++) begin
            pix_valid = 1'b1; pix_in = 8'(8'h20 + i);
            tick();
        end
        pix_valid = 1'b0;
        tick();
        chk("t3_accepted", m_acc, 4);
        chk("t3_overflow", overflow, 1);
        chk("t3_ready_when_full", pix_ready, 0);
        chk("t3_no_tx_while_stalled", txlog.size(), 0);
        tx_ready = 1'b1;
        repeat (10) tick();
        want = '{8'h08, 8'h01, 8'h20, 8'h21, 8'h22, 8'h23};
        chk_log("t3_bytes", want);
        chk("t3_still_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t3_rst_overflow", overflow, 0);

        // reset mid-frame, then a fresh 1x1 frame
        new_case(); tx_ready = 1'b1;
        do_start(8'd4, 8'd4);
        for (int i = 0; i < 16 && txlog.size() < 4; i++) begin
            pix_valid = 1'b1; pix_in = 8'(8'h40 + i);
            tick();
        end
        chk("t5_bytes_before_rst", txlog.size(), 4);
        pix_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_tx_valid", tx_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_pix_ready", pix_ready, 0);
        new_case();
        do_start(8'd1, 8'd1);
        pix_valid = 1'b1; pix_in = 8'hAA;
        tick();
        pix_valid = 1'b0;
        wait_idle("t5", 20);
        want = '{8'h01, 8'h01, 8'hAA};
        chk_log("t5_bytes", want);
        chk("t5_done_pulses", n_done, 1);
        chk("t5_overflow", overflow, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
